// File: rtl/tdc_capture_ctrl.sv
// TDC measurement sequencer: discards settle snapshots, accumulates 2^g_SAMPLES_LOG2 popcounts.
// Optional min/max tracking is built only when TDC_MINMAX_EN is defined.
module tdc_capture_ctrl #(
    parameter int g_LEN          = 64,
    parameter int g_SAMPLES_LOG2 = 4,
    parameter int g_SETTLE       = 2,
    localparam int CW            = $clog2(g_LEN + 1),
    localparam int SW            = CW + g_SAMPLES_LOG2
) (
    input  logic                      clkSample,
    input  logic                      rst,
    input  logic                      start,
    input  logic [g_LEN-1:0]          clkProp,
    input  logic                      result_ready,
    output logic                      busy,
    output logic                      result_valid,
    output logic [SW-1:0]             result_sum,
    output logic [CW-1:0]             result_min,
    output logic [CW-1:0]             result_max,
    output logic [g_SAMPLES_LOG2:0]   overrun_cnt
);

    localparam int N    = 1 << g_SAMPLES_LOG2;
    localparam int SETW = (g_SETTLE > 0) ? $clog2(g_SETTLE + 1) : 1;
    localparam int KW   = (SETW > g_SAMPLES_LOG2 + 1) ? SETW : g_SAMPLES_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] cnt;
    logic [CW-1:0] count;
    logic          last_settle, last_accum;

    // Popcount rather than first-zero search so bubbles do not shift the count.
    always_comb begin
        count = '0;
        for (int i = 0; i < g_LEN; i++)
            count = count + CW'(clkProp[i]);
    end

    assign last_settle = (int'(cnt) == g_SETTLE - 1);
    assign last_accum  = (int'(cnt) == N - 1);

    always_ff @(posedge clkSample or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        result_valid = (state == DONE);
        case (state)
            IDLE:   if (start) state_nxt = (g_SETTLE == 0) ? ACCUM : SETTLE;
            SETTLE: if (last_settle) state_nxt = ACCUM;
            ACCUM:  if (last_accum) state_nxt = DONE;
            DONE:   if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkSample or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            result_sum  <= '0;
            overrun_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        result_sum  <= '0;
                        overrun_cnt <= '0;
                    end
                end
                SETTLE: cnt <= last_settle ? '0 : cnt + 1'b1;
                ACCUM: begin
                    cnt        <= cnt + 1'b1;
                    result_sum <= result_sum + SW'(count);
                    if (count == CW'(g_LEN))
                        overrun_cnt <= overrun_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TDC_MINMAX_EN
    always_ff @(posedge clkSample or posedge rst) begin
        if (rst) begin
            result_min <= '0;
            result_max <= '0;
        end else if (state == IDLE && start) begin
            result_min <= CW'(g_LEN);
            result_max <= '0;
        end else if (state == ACCUM) begin
            if (count < result_min) result_min <= count;
            if (count > result_max) result_max <= count;
        end
    end
`else
    assign result_min = '0;
    assign result_max = '0;
`endif

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Scoreboard bench for tdc_capture_ctrl at default parameters (64-bit chain, 16 samples, 2 settle).
module tb_tdc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] clkProp;
    logic        result_ready;
    logic        busy, result_valid;
    logic [10:0] result_sum;
    logic [6:0]  result_min, result_max;
    logic [4:0]  overrun_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [10:0] sum;
        logic [6:0]  mn;
        logic [6:0]  mx;
        logic [4:0]  ov;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] seq [18];

    tdc_capture_ctrl dut (
        .clkSample    (clk),
        .rst          (rst),
        .start        (start),
        .clkProp      (clkProp),
        .result_ready (result_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result_sum   (result_sum),
        .result_min   (result_min),
        .result_max   (result_max),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] mm(input int v);
`ifdef TDC_MINMAX_EN
        return 7'(v);
`else
        return 7'(v * 0);
`endif
    endfunction

    function automatic exp_t mk(input int s, input int mn, input int mx, input int ov);
        exp_t e;
        e.sum = 11'(s);
        e.mn  = mm(mn);
        e.mx  = mm(mx);
        e.ov  = 5'(ov);
        return e;
    endfunction

    // Compares whenever a result is presented; pops only on the handshake.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                chk("sum", result_sum, sb[0].sum);
                chk("min", result_min, sb[0].mn);
                chk("max", result_max, sb[0].mx);
                chk("overrun", overrun_cnt, sb[0].ov);
                if (result_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic measure(input exp_t e, input bit stall);
        sb.push_back(e);
        result_ready = !stall;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", result_valid, 0);
        for (int k = 0; k < 18; k++) begin
            clkProp = seq[k];
            @(posedge clk); #1;
            if (k == 16) chk("valid_early", result_valid, 0);
        end
        chk("valid_latency", result_valid, 1);
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                start   = 1'b1;
                clkProp = ~64'h0;
                @(posedge clk); #1;
                chk("stall_valid_held", result_valid, 1);
                chk("stall_busy", busy, 1);
            end
            start        = 1'b0;
            result_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("valid_dropped", result_valid, 0);
        chk("idle_after_hs", busy, 0);
    endtask

    task automatic fill_const(input logic [63:0] v);
        for (int k = 0; k < 18; k++) seq[k] = v;
    endtask

    initial begin
        logic [63:0] one;
        one          = 64'h1;
        rst          = 1'b1;
        start        = 1'b0;
        clkProp      = '0;
        result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_sum", result_sum, 0);
        chk("rst_min", result_min, 0);
        chk("rst_max", result_max, 0);
        chk("rst_ovr", overrun_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill_const(64'h0000_0000_0000_FFFF);
        measure(mk(256, 16, 16, 0), 1'b0);

        fill_const(64'h0000_0000_0000_FFEF);
        measure(mk(240, 15, 15, 0), 1'b0);

        // Settle snapshots carry count 10; accumulated ones ramp 20..35.
        seq[0] = (one << 10) - 1;
        seq[1] = (one << 10) - 1;
        for (int k = 0; k < 16; k++) seq[k+2] = (one << (20 + k)) - 1;
        measure(mk(440, 20, 35, 0), 1'b0);

        fill_const(64'h0);
        seq[2+3]  = ~64'h0;
        seq[2+7]  = ~64'h0;
        seq[2+11] = ~64'h0;
        measure(mk(192, 0, 64, 3), 1'b0);

        fill_const(64'h0000_0000_0000_FFFF);
        measure(mk(256, 16, 16, 0), 1'b1);
        // Immediate restart in the single IDLE cycle after the stalled handshake.
        fill_const(64'h0000_0000_0000_FFEF);
        measure(mk(240, 15, 15, 0), 1'b0);

        // Abort mid-ACCUM with an asynchronous reset between edges.
        fill_const(~64'h0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clkProp = seq[k];
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", result_valid, 0);
        chk("arst_sum", result_sum, 0);
        chk("arst_min", result_min, 0);
        chk("arst_max", result_max, 0);
        chk("arst_ovr", overrun_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_stays_idle", busy, 0);
        fill_const(64'h0000_0000_0000_FFFF);
        measure(mk(256, 16, 16, 0), 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule

// File: doc/tdc_capture_ctrl.md
# tdc_capture_ctrl

Measurement sequencer for the carry-chain TDC. On a start request it discards a configurable number of settling snapshots of the TDC thermometer output, then converts the next 2^g_SAMPLES_LOG2 snapshots to bubble-tolerant edge counts and accumulates them. The result (sum, plus optional min/max) is presented to the downstream reader over a valid/ready handshake. It sits directly behind the TDC's registered `clkProp` output, in the same `clkSample` domain.

## Interface
- `g_LEN`, 64: TDC chain length in bits; multiple of 4.
- `g_SAMPLES_LOG2`, 4: log2 of the number of accumulated samples, N = 2^g_SAMPLES_LOG2; range 0..16.
- `g_SETTLE`, 2: snapshots discarded after start; 0 allowed.
- Derived: CW = $clog2(g_LEN+1) (7 for 64); SW = CW + g_SAMPLES_LOG2 (11).

- `clkSample` in 1: sole clock, same clock that samples the TDC.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: measurement request, sampled in IDLE only.
- `clkProp` in g_LEN: registered TDC thermometer snapshot.
- `result_ready` in 1: downstream accepts the result.
- `busy` out 1: high in SETTLE, ACCUM, DONE.
- `result_valid` out 1: result held stable while high.
- `result_sum` out SW: sum of N edge counts.
- `result_min` out CW: smallest edge count in the window.
- `result_max` out CW: largest edge count in the window.
- `overrun_cnt` out g_SAMPLES_LOG2+1: samples with all g_LEN bits set (edge ran off the chain).

## Operation
- Edge count = popcount(`clkProp`), range 0..g_LEN. Popcount is used instead of first-zero search, so bubbles do not shift the count.
- FSM states: IDLE, SETTLE, ACCUM, DONE.
- IDLE: `start`=1 clears sum, overrun_cnt, min (to g_LEN) and max (to 0). Next state is SETTLE, or ACCUM if g_SETTLE=0.
- SETTLE: a cycle counter runs from 0. After g_SETTLE edges the block goes to ACCUM. `clkProp` is ignored.
- ACCUM: every edge adds count to sum, updates min/max, and increments overrun_cnt when count=g_LEN. After the N-th accumulating edge the block goes to DONE with `result_valid`=1.
- DONE: outputs are frozen. The edge where `result_valid`&&`result_ready` returns to IDLE and drops `result_valid`. `start` is ignored here.
- `start` outside IDLE is ignored, with no queuing.
- Arithmetic: sum is unsigned SW bits and cannot overflow, because the maximum is g_LEN·N < 2^SW. overrun_cnt is wide enough to hold N.
- Reset, including mid-measurement: state=IDLE, busy=0, result_valid=0, result_sum=0, result_min=0, result_max=0, overrun_cnt=0, counters=0. Accumulation restarts only on a new `start`.

## Timing
- Edge E0 samples `start` in IDLE, and `busy` is 1 after E0.
- Samples accumulated are the `clkProp` values present before edges E0+g_SETTLE+1 through E0+g_SETTLE+N.
- `result_valid` is 1 after edge E0+g_SETTLE+N. Start-to-valid latency is g_SETTLE+N cycles.
- Handshake: `result_valid` never drops without `result_ready`. With `result_ready` held high, valid lasts exactly 1 cycle.
- Earliest restart: `start` at the edge after the handshake edge (one IDLE cycle).
- Popcount is combinational from registered `clkProp` into the accumulator, so there is one register-to-register path per edge.

## Configuration
- `TDC_MINMAX_EN` defined: min/max tracking is implemented as described above.
- `TDC_MINMAX_EN` undefined: min/max registers and comparators are not built, and `result_min`/`result_max` are tied to 0. Sum, overrun_cnt and handshake timing are unchanged.

## Test plan
Defaults g_LEN=64, g_SAMPLES_LOG2=4, g_SETTLE=2.
- Constant `clkProp`=64'h0000_0000_0000_FFFF, pulse `start` → valid after 18 cycles, sum=256, min=max=16, overrun_cnt=0.
- Bubbled code 64'h0000_0000_0000_FFEF held → sum=240, min=max=15.
- Ramp: count 10 in the 2 settle cycles, then counts 20..35 → sum=440, min=20, max=35. This confirms settle samples are discarded.
- All-ones on 3 of 16 samples, zero otherwise → sum=192, overrun_cnt=3, min=0, max=64.
- `result_ready`=0 for 5 cycles → outputs stable and `start` ignored; ready=1 → IDLE next edge. A `start` in the following cycle begins a new measurement.
- Assert `rst` asynchronously mid-ACCUM → all outputs 0 immediately, and a new `start` yields correct sum. Repeat with `TDC_MINMAX_EN` undefined → min/max are 0 and sum is unchanged.
